// File: rtl/mul_add.sv
// mul_add: sequential multiply-accumulate, Result = A*B + C.
// Rebuilds a dividend from quotient (A), divisor (B) and remainder (C) with a
// radix-2 shift-add loop: one multiplier bit per clock, WIDTH iterations, then
// a single finishing edge that folds in the addend and flags overflow.
// It uses the same start/done/busy handshake as the other multi-cycle ALU units.
module mul_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Result,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  // The counter only has to reach WIDTH-1. Keep at least one bit so the
  // declaration stays legal for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [2*WIDTH-1:0]   r_acc;       // running partial-product sum
  logic [2*WIDTH-1:0]   r_mcand;     // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]     r_mplier;    // multiplier, shifted right each iteration
  logic [WIDTH-1:0]     r_addend;
  logic [CNT_W-1:0]     r_cnt;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH:0]     w_sum;

  // Any bit at or above WIDTH means the true result does not fit in Result.
  function automatic logic carry_out(input logic [2*WIDTH:0] s);
    return |s[2*WIDTH:WIDTH];
  endfunction

  // Conditionally add the shifted multiplicand when the current multiplier
  // bit is set. The add is full 2*WIDTH wide, so nothing is lost before
  // FINISH.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The final sum carries one extra bit, so a carry out of the
  // acc + addend add is seen by the overflow check.
  assign w_sum = {1'b0, r_acc} + {{(WIDTH + 1){1'b0}}, r_addend};

  assign busy = (r_state != IDLE);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: start is honoured only in IDLE, so it is ignored while busy.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = CALC;
      CALC:    if (r_cnt == LAST_ITER) w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture operands on the accepting edge, then one shift-add step per CALC edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_addend <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mplier <= A;
            r_mcand  <= {{WIDTH{1'b0}}, B};
            r_addend <= C;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: begin
          // FINISH only reads the accumulator and addend; nothing to update.
        end
      endcase
    end
  end

  // Outputs: Result/overflow update only on the FINISH edge and hold
  // otherwise. done is high for exactly the one cycle after FINISH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (r_state == FINISH);
      if (r_state == FINISH) begin
        Result   <= w_sum[WIDTH-1:0];
        overflow <= carry_out(w_sum);
      end
    end
  end

endmodule

// File: tb/tb_mul_add.sv
// Testbench for mul_add: directed scenarios plus randomized operands,
// checked against a plain-arithmetic model of A*B + C.
module tb_mul_add;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A, B, C;
  logic [W-1:0] Result;
  logic         overflow;
  logic         done;
  logic         busy;

  int n_assert;
  int n_fail;

  mul_add #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .C        (C),
    .Result   (Result),
    .overflow (overflow),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the mathematical value of a*b+c, kept at 65 bits.
  function automatic logic [64:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return 65'(a) * 65'(b) + 65'(c);
  endfunction

  // Drive start for one edge. If on_neg is set, first align to a falling edge.
  // Returns #1 after the accepting edge, with the operands scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input bit on_neg);
    if (on_neg) @(negedge clk);
    start = 1'b1; A = a; B = b; C = c;
    @(posedge clk);
    #1;
    start = 1'b0; A = $urandom; B = $urandom; C = $urandom;
  endtask

  // Count edges until done is seen (bounded). Also count cycles where busy was low.
  task automatic wait_done(output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    while (done !== 1'b1 && lat < 80) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] c);
    logic [64:0] full;
    full = model(a, b, c);
    chk({tag, "_result"}, 64'(Result), 64'(full[W-1:0]));
    chk({tag, "_ovf"}, 64'(overflow), 64'(|full[64:W]));
  endtask

  // Full operation: launch, latency, busy, result, and a one-cycle done pulse.
  task automatic do_op(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
    int lat, bl;
    launch(a, b, c, 1'b1);
    wait_done(lat, bl);
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_busy"}, 64'(bl), 64'd0);
    check_result(tag, a, b, c);
    @(posedge clk);
    #1;
    chk({tag, "_donepulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bl;
    logic [W-1:0] ra, rb, rc, hold_r;
    logic         hold_o;

    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0; start = 1'b0; A = '0; B = '0; C = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    do_op("basic", 32'd7, 32'd5, 32'd3);
    chk("basic_val", 64'(Result), 64'd38);
    do_op("modrt", 32'd14, 32'd7, 32'd2);
    chk("modrt_val", 64'(Result), 64'd100);
    do_op("ovf1", 32'h0001_0000, 32'h0001_0000, 32'd1);
    chk("ovf1_val", 64'({overflow, Result}), 64'h1_0000_0001);
    do_op("ovf2", 32'hFFFF_FFFF, 32'd1, 32'd1);
    chk("ovf2_val", 64'({overflow, Result}), 64'h1_0000_0000);
    do_op("zero", 32'd0, 32'hDEAD_BEEF, 32'h55);
    chk("zero_val", 64'({overflow, Result}), 64'h0_0000_0055);
    do_op("zerob", 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);

    // Outputs hold between operations while start stays low.
    hold_r = Result;
    hold_o = overflow;
    repeat (5) begin
      @(negedge clk);
      A = $urandom; B = $urandom; C = $urandom;
    end
    #1;
    chk("hold_result", 64'(Result), 64'(hold_r));
    chk("hold_ovf", 64'(overflow), 64'(hold_o));
    chk("hold_busy", 64'(busy), 64'd0);

    // Handshake: start while busy is ignored, back-to-back start is accepted.
    launch(32'd3, 32'd4, 32'd0, 1'b1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; A = 32'd9; B = 32'd9; C = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bl);
    chk("hs1_lat", 64'(lat + 10), 64'(LAT));
    chk("hs1_busy", 64'(bl), 64'd0);
    chk("hs1_val", 64'(Result), 64'd12);
    launch(32'd2, 32'd2, 32'd2, 1'b0);
    wait_done(lat, bl);
    chk("hs2_lat", 64'(lat), 64'(LAT));
    chk("hs2_busy", 64'(bl), 64'd0);
    chk("hs2_val", 64'(Result), 64'd6);
    @(posedge clk);
    #1;

    // Reset mid-operation aborts and clears the outputs at once.
    launch(32'd100, 32'd100, 32'd0, 1'b1);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_result", 64'(Result), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_nodone", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op("postrst", 32'd1, 32'd1, 32'd1);
    chk("postrst_val", 64'(Result), 64'd2);

    // Randomized operands, with operand classes biased toward edge values.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 65535); rb = $urandom_range(0, 65535); end
        2: begin ra = 32'hFFFF_FFFF - $urandom_range(0, 3); rb = $urandom_range(0, 2); end
        default: begin ra = $urandom_range(0, 1); rb = $urandom; end
      endcase
      rc = ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FFFF;
      do_op($sformatf("rnd%0d", i), ra, rb, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
